// File: rtl/cv32e40p_pkg.sv
// Shared types and constants for the CV32E40P writeback arbiter.
// Register addresses are 6 bits wide, so the pending bitmap covers 64 registers.
package cv32e40p_pkg;

   localparam int WB_ADDR_WIDTH = 6;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_NUM_REGS   = 1 << WB_ADDR_WIDTH;

   typedef enum logic {
      WB_ARB_FIXED,
      WB_ARB_RR
   } wb_arb_mode_e;

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// Per-source result buffer holding {waddr, wdata} entries in arrival order.
// Also reports which registers it holds unwritten results for.
module cv32e40p_wb_fifo
   import cv32e40p_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WB_ADDR_WIDTH-1:0] push_waddr,
   input  logic [WB_DATA_WIDTH-1:0] push_wdata,
   output logic [WB_ADDR_WIDTH-1:0] head_waddr,
   output logic [WB_DATA_WIDTH-1:0] head_wdata,
   output logic                     full,
   output logic                     empty,
   output logic [WB_NUM_REGS-1:0]   pending
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [PTR_W-1:0]         rd_ptr;
   logic [PTR_W-1:0]         wr_ptr;
   logic [DEPTH-1:0]         vld;
   logic [WB_ADDR_WIDTH-1:0] mem_waddr [DEPTH];
   logic [WB_DATA_WIDTH-1:0] mem_wdata [DEPTH];

   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      bump = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full       = &vld;
   assign empty      = ~|vld;
   assign head_waddr = mem_waddr[rd_ptr];
   assign head_wdata = mem_wdata[rd_ptr];

   // Pop clears before push sets, so a push+pop on a full buffer keeps the slot valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         vld    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         vld    <= '0;
      end else begin
         if (pop) begin
            vld[rd_ptr] <= 1'b0;
            rd_ptr      <= bump(rd_ptr);
         end
         if (push) begin
            vld[wr_ptr] <= 1'b1;
            wr_ptr      <= bump(wr_ptr);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_waddr[wr_ptr] <= push_waddr;
         mem_wdata[wr_ptr] <= push_wdata;
      end
   end

   always_comb begin
      pending = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (vld[k] && (mem_waddr[k] != '0)) pending[mem_waddr[k]] = 1'b1;
      end
   end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// Writeback arbiter: merges results from several execution units onto the
// register-file write ports, buffering whatever cannot be written this cycle.
module cv32e40p_wb_arbiter
   import cv32e40p_pkg::*;
#(
   parameter int           NUM_SRC    = 3,
   parameter int           NUM_PORTS  = 2,
   parameter int           FIFO_DEPTH = 2,
   parameter wb_arb_mode_e ARB_MODE   = WB_ARB_FIXED
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic [NUM_SRC-1:0]                 src_valid_i,
   output logic [NUM_SRC-1:0]                 src_ready_o,
   input  logic [NUM_SRC*WB_ADDR_WIDTH-1:0]   src_waddr_i,
   input  logic [NUM_SRC*WB_DATA_WIDTH-1:0]   src_wdata_i,
   input  logic                               flush_i,
   output logic [NUM_PORTS-1:0]               rf_we_o,
   output logic [NUM_PORTS*WB_ADDR_WIDTH-1:0] rf_waddr_o,
   output logic [NUM_PORTS*WB_DATA_WIDTH-1:0] rf_wdata_o,
   output logic [WB_NUM_REGS-1:0]             pending_o,
   output logic [15:0]                        contention_cnt_o
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   logic [NUM_SRC-1:0]       fifo_full;
   logic [NUM_SRC-1:0]       fifo_empty;
   logic [NUM_SRC-1:0]       push;
   logic [NUM_SRC-1:0]       pop;
   logic [NUM_SRC-1:0]       grant;
   logic [NUM_SRC-1:0]       cand_valid;
   logic [WB_ADDR_WIDTH-1:0] head_waddr [NUM_SRC];
   logic [WB_DATA_WIDTH-1:0] head_wdata [NUM_SRC];
   logic [WB_ADDR_WIDTH-1:0] cand_waddr [NUM_SRC];
   logic [WB_DATA_WIDTH-1:0] cand_wdata [NUM_SRC];
   logic [WB_NUM_REGS-1:0]   fifo_pending [NUM_SRC];

   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] last_idx;
   logic             contention;
   logic             blocked;
   int               n_granted;
   int               n_cand;
   int               start;
   int               rank [NUM_SRC];
   int               port_of [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      // An empty buffer lets the incoming result compete directly (cut-through).
      assign cand_valid[i] = !fifo_empty[i] || src_valid_i[i];
      assign cand_waddr[i] = fifo_empty[i] ? src_waddr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]
                                           : head_waddr[i];
      assign cand_wdata[i] = fifo_empty[i] ? src_wdata_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH]
                                           : head_wdata[i];

      assign src_ready_o[i] = !fifo_full[i] || (grant[i] && !fifo_empty[i]) || flush_i;
      assign pop[i]         = grant[i] && !fifo_empty[i];
      assign push[i]        = src_valid_i[i] && src_ready_o[i] && !(fifo_empty[i] && grant[i]);

      cv32e40p_wb_fifo #(
         .DEPTH(FIFO_DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst_n     (rst_n),
         .push      (push[i]),
         .pop       (pop[i]),
         .flush     (flush_i),
         .push_waddr(src_waddr_i[i*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]),
         .push_wdata(src_wdata_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH]),
         .head_waddr(head_waddr[i]),
         .head_wdata(head_wdata[i]),
         .full      (fifo_full[i]),
         .empty     (fifo_empty[i]),
         .pending   (fifo_pending[i])
      );
   end

   // Walk candidates in priority order; a candidate whose nonzero address matches
   // any higher-priority candidate waits so same-register writes stay ordered.
   always_comb begin
      grant      = '0;
      contention = 1'b0;
      blocked    = 1'b0;
      last_idx   = '0;
      n_granted  = 0;
      n_cand     = 0;
      start      = (ARB_MODE == WB_ARB_RR) ? int'(rr_ptr) : 0;
      for (int s = 0; s < NUM_SRC; s++) begin
         rank[s]    = (s + NUM_SRC - start) % NUM_SRC;
         port_of[s] = 0;
      end
      for (int r = 0; r < NUM_SRC; r++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (rank[s] == r && cand_valid[s]) begin
               n_cand  = n_cand + 1;
               blocked = 1'b0;
               for (int t = 0; t < NUM_SRC; t++) begin
                  if (rank[t] < r && cand_valid[t] && cand_waddr[t] == cand_waddr[s]
                      && cand_waddr[s] != '0) blocked = 1'b1;
               end
               if (blocked) begin
                  contention = 1'b1;
               end else if (n_granted < NUM_PORTS && !flush_i && rst_n) begin
                  grant[s]   = 1'b1;
                  port_of[s] = n_granted;
                  last_idx   = IDX_W'(s);
                  n_granted  = n_granted + 1;
               end
            end
         end
      end
      if (n_cand > NUM_PORTS) contention = 1'b1;
   end

   // Writes to x0 consume a port but never raise its write enable.
   always_comb begin
      rf_we_o    = '0;
      rf_waddr_o = '0;
      rf_wdata_o = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if (grant[s] && port_of[s] == p && cand_waddr[s] != '0) begin
               rf_we_o[p]                                       = 1'b1;
               rf_waddr_o[p*WB_ADDR_WIDTH +: WB_ADDR_WIDTH]     = cand_waddr[s];
               rf_wdata_o[p*WB_DATA_WIDTH +: WB_DATA_WIDTH]     = cand_wdata[s];
            end
         end
      end
   end

   always_comb begin
      pending_o = '0;
      for (int i = 0; i < NUM_SRC; i++) pending_o = pending_o | fifo_pending[i];
   end

   // Flush freezes both the round-robin pointer and the contention statistic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr           <= '0;
         contention_cnt_o <= '0;
      end else if (!flush_i) begin
         if (|grant) begin
            if (int'(last_idx) == NUM_SRC - 1) rr_ptr <= '0;
            else                               rr_ptr <= last_idx + 1'b1;
         end
         if (contention && contention_cnt_o != 16'hFFFF)
            contention_cnt_o <= contention_cnt_o + 16'd1;
      end
   end

endmodule

// File: doc/cv32e40p_wb_arbiter.md
CV32E40P_WB_ARBITER -- requirements
Module: cv32e40p_wb_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3: number of result sources (index 0 = ALU/MULT, 1 = APU, 2 = LSU); range 2..4.
REQ-002 SHALL have parameter NUM_PORTS, default 2: number of register-file write ports; range 1..NUM_SRC.
REQ-003 SHALL have parameter FIFO_DEPTH, default 2: per-source result buffer depth; power of two, 1..8.
REQ-004 SHALL have parameter ARB_MODE, default WB_ARB_FIXED: arbitration mode, either WB_ARB_FIXED or WB_ARB_RR.
REQ-005 SHALL have ports clk (input, 1) as the clock, and rst_n (input, 1) as the reset; one clock, reset asynchronous and active-low.
REQ-006 SHALL have src_valid_i (input, NUM_SRC): per-source result valid.
REQ-007 SHALL have src_ready_o (output, NUM_SRC): per-source buffer can accept.
REQ-008 SHALL have src_waddr_i (input, NUM_SRC x 6): destination register per source.
REQ-009 SHALL have src_wdata_i (input, NUM_SRC x 32): result data per source.
REQ-010 SHALL have flush_i (input, 1): discard all buffered results.
REQ-011 SHALL have rf_we_o (output, NUM_PORTS): write enable per port.
REQ-012 SHALL have rf_waddr_o (output, NUM_PORTS x 6): write address per port.
REQ-013 SHALL have rf_wdata_o (output, NUM_PORTS x 32): write data per port.
REQ-014 SHALL have pending_o (output, NUM_SRC x 6): per-source list of buffered destination addresses is NOT exported; instead pending_o (output, 64) is a bitmap of all registers with a buffered, unwritten result, used by ID for hazard stalls.
REQ-015 SHALL have contention_cnt_o (output, 16): saturating count of contention cycles.

Function
REQ-016 Each source SHALL own a FIFO_DEPTH-entry FIFO holding {waddr, wdata}; a transfer occurs when src_valid_i & src_ready_o are both high.
REQ-017 src_ready_o[i] SHALL be high when FIFO i is not full, or when it is full and its head is granted in the same cycle.
REQ-018 Candidate i SHALL be the FIFO head when FIFO i is non-empty, else the incoming transfer (cut-through, zero latency).
REQ-019 Each cycle, up to NUM_PORTS candidates SHALL be granted; granted candidates fill ports in ascending order, and unused ports drive we=0, waddr=0, wdata=0.
REQ-020 In WB_ARB_FIXED mode, priority SHALL be by ascending source index.
REQ-021 In WB_ARB_RR mode, priority SHALL start at pointer p; after any grant cycle, p becomes (index of last granted source + 1) mod NUM_SRC.
REQ-022 Address conflict: if two candidates target the same nonzero waddr, only the higher-priority one SHALL be granted that cycle, and the other stays pending.
REQ-023 Candidates with waddr 0 SHALL be granted and popped without asserting rf_we_o.
REQ-024 A non-granted cut-through candidate SHALL be pushed into its FIFO; a granted head SHALL be popped, and a simultaneous push and pop on a full FIFO SHALL be legal.
REQ-025 Results from one source SHALL be written in arrival order.
REQ-026 pending_o[r] SHALL be 1 iff any FIFO entry holds waddr r, r != 0, and it SHALL be combinational from FIFO state.
REQ-027 contention_cnt_o SHALL increment by 1 in each cycle in which the number of candidates exceeds NUM_PORTS or an address conflict defers a candidate, and SHALL saturate at 16'hFFFF.
REQ-028 flush_i SHALL empty all FIFOs at the next edge and suppress cut-through grants in that cycle; rf_we_o SHALL be 0 while flush_i is high.
REQ-029 When flush_i is high, the RR pointer and contention_cnt_o SHALL be unchanged.

Reset
REQ-030 On rst_n low, all FIFOs SHALL be empty, the RR pointer SHALL be 0, contention_cnt_o SHALL be 0, rf_we_o SHALL be 0, rf_waddr_o/rf_wdata_o SHALL be 0, src_ready_o SHALL be all 1s, and pending_o SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard buffered results without emitting any write.

Structure
REQ-032 The enum wb_arb_mode_e {WB_ARB_FIXED, WB_ARB_RR} and the constant WB_ADDR_WIDTH = 6 SHALL live in cv32e40p_pkg.
REQ-033 The per-source buffer SHALL be a sub-module, cv32e40p_wb_fifo, instantiated NUM_SRC times, exposing full, empty, head, push, pop and flush.

Verification
REQ-034 Cut-through: with NUM_PORTS=2, src0 sends (x5, 0x11) and src1 sends (x6, 0x22) in the same cycle -> both are written in that cycle on ports 0 and 1, and contention_cnt_o stays 0.
REQ-035 Contention: with NUM_PORTS=2, three sources are valid to x1, x2, x3 in the same cycle -> x1 and x2 are written that cycle, x3 the next cycle, pending_o[3]=1 for one cycle, and contention_cnt_o=1.
REQ-036 Conflict: src0 and src2 both target x7 with data 0xA and 0xB in the same cycle -> x7=0xA is written in cycle N and x7=0xB in cycle N+1.
REQ-037 Back-pressure: with NUM_PORTS=1, FIFO_DEPTH=2, src0 held valid and src1 sending 4 results -> src_ready_o[1] drops after 2 are buffered, and the results are written in order.
REQ-038 Round-robin: with ARB_MODE=RR, NUM_PORTS=1, and all 3 sources continuously valid -> grant order is 0,1,2,0,1,2.
REQ-039 Flush and reset: buffer 2 entries, then assert flush_i -> no writes occur, pending_o=0, and src_ready_o is all 1s; assert rst_n low mid-burst -> contention_cnt_o=0.
